// File: rtl/bht_update_queue.sv
`default_nettype none
// ============================================================================
//  Module   : bht_update_queue
//  Purpose  : Buffers resolved conditional-branch outcomes from two commit
//             ports in a circular FIFO and drains them to the branch history
//             table at one update per cycle. Also keeps a saturating count of
//             accepted mispredicted branches.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH      FIFO entries (power of two, >= 4)
//    CNT_WIDTH  width of the misprediction counter
//    VLEN       virtual address width of a branch PC
//  Ports
//    clk_i                 clock
//    rst_ni                synchronous active-low reset
//    flush_i               discard every buffered update, accept nothing
//    debug_mode_i          core in debug mode; new resolutions are dropped
//    resolve_valid_i[1:0]  per-port resolution valid (port 0 is older)
//    resolve_is_branch_i   resolution is a conditional branch
//    resolve_pc_i          branch PC per port
//    resolve_taken_i       actual outcome per port
//    resolve_pred_taken_i  predicted outcome per port
//    resolve_ready_o       room for two more entries this cycle
//    bht_update_o          {valid, pc[VLEN-1:0], taken}, MSB first
//    mispredict_cnt_o      saturating misprediction count
// ============================================================================
module bht_update_queue #(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned CNT_WIDTH = 32,
   parameter int unsigned VLEN      = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 flush_i,
   input  logic                 debug_mode_i,
   input  logic [1:0]           resolve_valid_i,
   input  logic [1:0]           resolve_is_branch_i,
   input  logic [1:0][VLEN-1:0] resolve_pc_i,
   input  logic [1:0]           resolve_taken_i,
   input  logic [1:0]           resolve_pred_taken_i,
   output logic                 resolve_ready_o,
   output logic [VLEN+1:0]      bht_update_o,
   output logic [CNT_WIDTH-1:0] mispredict_cnt_o
);

   localparam int unsigned          c_PTR_W     = $clog2(DEPTH);
   localparam int unsigned          c_OCC_W     = c_PTR_W + 1;
   localparam int unsigned          c_SUM_W     = CNT_WIDTH + 1;
   localparam logic [c_OCC_W-1:0]   c_READY_MAX = c_OCC_W'(DEPTH - 2);
   localparam logic [c_PTR_W-1:0]   c_PTR_ONE   = c_PTR_W'(1);
   localparam logic [CNT_WIDTH-1:0] c_CNT_MAX   = '1;

   // FIFO storage and bookkeeping
   logic [VLEN-1:0]      r_pc [DEPTH];
   logic [DEPTH-1:0]     r_taken;
   logic [c_PTR_W-1:0]   r_rptr;
   logic [c_PTR_W-1:0]   r_wptr;
   logic [c_OCC_W-1:0]   r_count;
   logic [CNT_WIDTH-1:0] r_mis_cnt;

   logic                 w_ready;
   logic                 w_pop;
   logic [1:0]           w_acc;
   logic [1:0]           w_mis;
   logic [1:0]           w_num_acc;
   logic [1:0]           w_num_mis;
   logic [c_PTR_W-1:0]   w_waddr1;
   logic [c_SUM_W-1:0]   w_mis_sum;

   always_comb begin
      // Ready depends only on registered occupancy, so there is no
      // combinational path from the resolve inputs to resolve_ready_o.
      w_ready = (r_count <= c_READY_MAX);
      w_pop   = (r_count != '0) && !flush_i;

      for (int i = 0; i < 2; i++) begin
         w_acc[i] = resolve_valid_i[i] & resolve_is_branch_i[i] & w_ready
                    & ~flush_i & ~debug_mode_i;
         w_mis[i] = w_acc[i] & (resolve_taken_i[i] ^ resolve_pred_taken_i[i]);
      end

      w_num_acc = {1'b0, w_acc[0]} + {1'b0, w_acc[1]};
      w_num_mis = {1'b0, w_mis[0]} + {1'b0, w_mis[1]};

      // Port 1 lands directly behind port 0, or in port 0's slot when
      // port 0 carried nothing this cycle.
      w_waddr1 = w_acc[0] ? (r_wptr + c_PTR_ONE) : r_wptr;

      // One extra bit catches the carry out for saturation.
      w_mis_sum = {1'b0, r_mis_cnt} + c_SUM_W'(w_num_mis);

      resolve_ready_o  = w_ready;
      bht_update_o     = {w_pop, r_pc[r_rptr], r_taken[r_rptr]};
      mispredict_cnt_o = r_mis_cnt;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_rptr    <= '0;
         r_wptr    <= '0;
         r_count   <= '0;
         r_taken   <= '0;
         r_mis_cnt <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_pc[i] <= '0;
         end
      end else begin
         if (w_acc[0]) begin
            r_pc[r_wptr]    <= resolve_pc_i[0];
            r_taken[r_wptr] <= resolve_taken_i[0];
         end
         if (w_acc[1]) begin
            r_pc[w_waddr1]    <= resolve_pc_i[1];
            r_taken[w_waddr1] <= resolve_taken_i[1];
         end

         if (flush_i) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
         end else begin
            r_wptr  <= r_wptr + c_PTR_W'(w_num_acc);
            r_rptr  <= r_rptr + c_PTR_W'(w_pop);
            r_count <= r_count + c_OCC_W'(w_num_acc) - c_OCC_W'(w_pop);
         end

         // Flush blocks acceptance, so it can never add mispredicts, and it
         // deliberately leaves the running count intact.
         r_mis_cnt <= w_mis_sum[CNT_WIDTH] ? c_CNT_MAX : w_mis_sum[CNT_WIDTH-1:0];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bht_update_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bht_update_queue
//  Purpose  : Self-checking bench for bht_update_queue. A queue-based
//             reference model pushes expected BHT updates; a monitor pops and
//             compares whenever the design presents a valid update.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bht_update_queue;

   localparam int DEPTH = 8;
   localparam int VLEN  = 64;
   localparam int CW_S  = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst_n;
   logic                 flush;
   logic                 dbg;
   logic [1:0]           vld;
   logic [1:0]           br;
   logic [1:0]           tk;
   logic [1:0]           pt;
   logic [1:0][VLEN-1:0] pc;

   logic                 ready;
   logic                 ready_s;
   logic [VLEN+1:0]      upd;
   logic [VLEN+1:0]      upd_s;
   logic [31:0]          cnt;
   logic [CW_S-1:0]      cnt_s;

   bht_update_queue #(.DEPTH(DEPTH), .CNT_WIDTH(32), .VLEN(VLEN)) u_dut (
      .clk_i                (clk),
      .rst_ni               (rst_n),
      .flush_i              (flush),
      .debug_mode_i         (dbg),
      .resolve_valid_i      (vld),
      .resolve_is_branch_i  (br),
      .resolve_pc_i         (pc),
      .resolve_taken_i      (tk),
      .resolve_pred_taken_i (pt),
      .resolve_ready_o      (ready),
      .bht_update_o         (upd),
      .mispredict_cnt_o     (cnt)
   );

   // Narrow-counter instance on the same stimulus, to reach saturation.
   bht_update_queue #(.DEPTH(DEPTH), .CNT_WIDTH(CW_S), .VLEN(VLEN)) u_dut_s (
      .clk_i                (clk),
      .rst_ni               (rst_n),
      .flush_i              (flush),
      .debug_mode_i         (dbg),
      .resolve_valid_i      (vld),
      .resolve_is_branch_i  (br),
      .resolve_pc_i         (pc),
      .resolve_taken_i      (tk),
      .resolve_pred_taken_i (pt),
      .resolve_ready_o      (ready_s),
      .bht_update_o         (upd_s),
      .mispredict_cnt_o     (cnt_s)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state: expected FIFO contents {pc, taken}, occupancy,
   // and the two misprediction counters.
   logic [VLEN:0]   exp_q[$];
   int              m_count = 0;
   longint unsigned m_mis   = 0;
   longint unsigned m_mis_s = 0;
   bit              mon_en  = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Model: evaluates the queue rules on each clock edge.
   always @(posedge clk) begin
      if (!rst_n) begin
         m_count = 0;
         exp_q.delete();
         m_mis   = 0;
         m_mis_s = 0;
         mon_en  = 1'b1;
      end else begin
         int  nacc;
         int  nmis;
         bit  room;
         bit  popped;
         nacc   = 0;
         nmis   = 0;
         room   = (m_count <= DEPTH - 2);
         popped = (m_count != 0) && !flush;
         for (int i = 0; i < 2; i++) begin
            if (vld[i] && br[i] && room && !flush && !dbg) begin
               exp_q.push_back({pc[i], tk[i]});
               nacc++;
               if (tk[i] != pt[i]) nmis++;
            end
         end
         if (flush) begin
            m_count = 0;
            exp_q.delete();
         end else begin
            m_count = m_count + nacc - (popped ? 1 : 0);
         end
         m_mis   = (m_mis + nmis > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_mis + nmis;
         m_mis_s = (m_mis_s + nmis > 7) ? 7 : m_mis_s + nmis;
      end
   end

   // Monitor: checks outputs mid-cycle and pops the scoreboard on each update.
   always @(negedge clk) begin
      if (mon_en) begin
         logic [VLEN:0] e;
         check("out_valid", upd[VLEN+1], (m_count != 0) && !flush);
         check("out_valid_s", upd_s[VLEN+1], (m_count != 0) && !flush);
         if (upd[VLEN+1] === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL out_unexpected: got update pc=0x%0h, expected none (t=%0t)",
                        upd[VLEN:1], $time);
            end else begin
               e = exp_q.pop_front();
               check("out_entry", upd[VLEN:0], e);
            end
         end
         check("ready", ready, m_count <= DEPTH - 2);
         check("ready_s", ready_s, m_count <= DEPTH - 2);
         check("mis_cnt", cnt, m_mis);
         check("mis_cnt_s", cnt_s, m_mis_s);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      vld   = '0;
      br    = '0;
      tk    = '0;
      pt    = '0;
      flush = 1'b0;
      dbg   = 1'b0;
   endtask

   task automatic set_port(input int p, input logic v, input logic b,
                           input logic [VLEN-1:0] a, input logic t, input logic q);
      vld[p] = v;
      br[p]  = b;
      pc[p]  = a;
      tk[p]  = t;
      pt[p]  = q;
   endtask

   initial begin
      longint unsigned mis_before;
      rst_n = 1'b0;
      pc    = '0;
      idle();
      repeat (3) cyc();
      rst_n = 1'b1;
      cyc();
      check("rst_update", upd, 0);
      check("rst_ready", ready, 1);
      check("rst_cnt", cnt, 0);

      // Single mispredicted branch on port 0
      set_port(0, 1, 1, 64'h8000_0010, 1, 0);
      cyc();
      idle();
      check("single_valid", upd[VLEN+1], 1);
      check("single_pc", upd[VLEN:1], 64'h8000_0010);
      check("single_taken", upd[0], 1);
      cyc();
      check("single_drained", upd[VLEN+1], 0);
      check("single_cnt", cnt, 1);

      // Six cycles of dual branches fill the queue to DEPTH-1
      for (int k = 0; k < 6; k++) begin
         set_port(0, 1, 1, 64'h1000 + 16 * k, k[0], 0);
         set_port(1, 1, 1, 64'h1008 + 16 * k, 1, 1);
         cyc();
      end
      idle();
      check("full_ready_low", ready, 0);
      repeat (12) cyc();
      check("full_drained", exp_q.size(), 0);

      // Non-branch on port 0, branch on port 1
      set_port(0, 1, 0, 64'h200, 1, 0);
      set_port(1, 1, 1, 64'h100, 0, 0);
      cyc();
      idle();
      check("mixed_valid", upd[VLEN+1], 1);
      check("mixed_pc", upd[VLEN:1], 64'h100);
      cyc();
      check("mixed_only_one", upd[VLEN+1], 0);

      // Debug mode drops new resolutions
      mis_before = m_mis;
      dbg = 1'b1;
      set_port(0, 1, 1, 64'h300, 1, 0);
      set_port(1, 1, 1, 64'h304, 0, 1);
      repeat (3) cyc();
      check("dbg_no_output", upd[VLEN+1], 0);
      check("dbg_cnt", cnt, mis_before);
      idle();

      // Flush with five entries buffered and both ports valid
      for (int k = 0; k < 4; k++) begin
         set_port(0, 1, 1, 64'h4000 + 16 * k, 0, 0);
         set_port(1, 1, 1, 64'h4008 + 16 * k, 1, 1);
         cyc();
      end
      set_port(0, 1, 1, 64'h5000, 1, 0);
      set_port(1, 1, 1, 64'h5008, 1, 0);
      flush = 1'b1;
      #1;
      check("flush_cycle_valid", upd[VLEN+1], 0);
      mis_before = m_mis;
      cyc();
      idle();
      check("post_flush_valid", upd[VLEN+1], 0);
      check("post_flush_ready", ready, 1);
      check("post_flush_cnt", cnt, mis_before);
      cyc();
      check("post_flush_empty", upd[VLEN+1], 0);

      // Counter saturation on the narrow instance
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         set_port(0, 1, 1, 64'h6000 + 4 * k, 1, 0);
         cyc();
      end
      idle();
      check("sat_pre", cnt_s, 6);
      set_port(0, 1, 1, 64'h7000, 1, 0);
      set_port(1, 1, 1, 64'h7004, 0, 1);
      cyc();
      idle();
      check("sat_reach", cnt_s, 7);
      check("sat_wide", cnt, 8);
      set_port(0, 1, 1, 64'h7010, 0, 1);
      set_port(1, 1, 1, 64'h7014, 1, 0);
      cyc();
      idle();
      check("sat_hold", cnt_s, 7);
      check("sat_wide2", cnt, 10);
      repeat (12) cyc();

      // Randomized traffic with a mid-stream reset; inputs hold while not ready
      for (int c = 0; c < 400; c++) begin
         rst_n = (c != 200);
         flush = ($urandom_range(0, 19) == 0);
         dbg   = ($urandom_range(0, 9) == 0);
         if (m_count <= DEPTH - 2) begin
            for (int p = 0; p < 2; p++) begin
               vld[p] = ($urandom_range(0, 3) != 0);
               br[p]  = ($urandom_range(0, 4) != 0);
               pc[p]  = {$urandom, $urandom};
               tk[p]  = 1'($urandom_range(0, 1));
               pt[p]  = 1'($urandom_range(0, 1));
            end
         end
         cyc();
      end
      idle();
      rst_n = 1'b1;
      repeat (20) cyc();
      check("final_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
